// File: rtl/dual_pipeline_top.sv
// Two DEPTH-stage demo pipelines sharing one global stall.
// Define GLOBAL_STALL_EN to build the periodic stall generator.
module dual_pipeline_top #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int STALL_PERIOD = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic              out_valid_1,
  output logic              out_valid_2
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
  } slot_t;

  logic stall;

`ifdef GLOBAL_STALL_EN
  localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(STALL_PERIOD - 1);

  logic [CW-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + CW'(1);
    if (cyc_q == CYC_LAST) cyc_d = '0;
  end

  assign stall = (cyc_q == CYC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`else
  assign stall = 1'b0;
`endif

  logic [DATA_W-1:0] seq1_q, seq1_d;
  logic [DATA_W-1:0] seq2_q, seq2_d;
  logic              tog_q, tog_d;

  slot_t p1_q [DEPTH];
  slot_t p1_d [DEPTH];
  slot_t p2_q [DEPTH];
  slot_t p2_d [DEPTH];

  // Invalid slots always carry zero data.
  function automatic slot_t op1(slot_t s);
    slot_t r;
    r = '0;
    if (s.vld) begin
      r.vld = 1'b1;
      r.dat = s.dat + DATA_W'(1);
    end
    return r;
  endfunction

  function automatic slot_t op2(slot_t s);
    slot_t r;
    r = '0;
    if (s.vld) begin
      r.vld = 1'b1;
      r.dat = s.dat << 1;
    end
    return r;
  endfunction

  always_comb begin
    seq1_d = seq1_q;
    seq2_d = seq2_q;
    tog_d  = tog_q;
    p1_d   = p1_q;
    p2_d   = p2_q;
    if (!stall) begin
      seq1_d  = seq1_q + DATA_W'(1);
      p1_d[0] = op1('{vld: 1'b1, dat: seq1_q});
      if (!tog_q) begin
        p2_d[0] = op2('{vld: 1'b1, dat: seq2_q});
        seq2_d  = seq2_q + DATA_W'(1);
      end else begin
        p2_d[0] = '0;
      end
      tog_d = ~tog_q;
      for (int k = 1; k < DEPTH; k++) begin
        p1_d[k] = op1(p1_q[k-1]);
        p2_d[k] = op2(p2_q[k-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq1_q <= '0;
      seq2_q <= '0;
      tog_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        p1_q[k] <= '0;
        p2_q[k] <= '0;
      end
    end else begin
      seq1_q <= seq1_d;
      seq2_q <= seq2_d;
      tog_q  <= tog_d;
      for (int k = 0; k < DEPTH; k++) begin
        p1_q[k] <= p1_d[k];
        p2_q[k] <= p2_d[k];
      end
    end
  end

  assign out_data_1  = p1_q[DEPTH-1].dat;
  assign out_valid_1 = p1_q[DEPTH-1].vld;
  assign out_data_2  = p2_q[DEPTH-1].dat;
  assign out_valid_2 = p2_q[DEPTH-1].vld;

endmodule

// File: tb/tb_dual_pipeline_top.sv
// Bench for dual_pipeline_top: arithmetic reference model
// driven by edge counts since reset.
module tb_dual_pipeline_top;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SP    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] out_data_1, out_data_2;
  logic          out_valid_1, out_valid_2;

  dual_pipeline_top #(
    .DATA_W(DW), .DEPTH(DEPTH), .STALL_PERIOD(SP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .out_data_1(out_data_1),
    .out_data_2(out_data_2),
    .out_valid_1(out_valid_1),
    .out_valid_2(out_valid_2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int e;
  int m;
  int dep_j;
  logic [DW-1:0] dep_val;

  logic [DW-1:0] x_d1, x_d2;
  logic          x_v1, x_v2;

  function automatic bit stall_at(int n);
    bit en;
`ifdef GLOBAL_STALL_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (n % SP == 0);
  endfunction

  function automatic logic [DW-1:0] src1(int j);
    if (j >= dep_j) return dep_val + DW'(j - dep_j);
    return DW'(j - 1);
  endfunction

  // Output after m issuing edges holds the source issued on edge m-DEPTH+1.
  function automatic void model();
    int j;
    x_d1 = '0; x_v1 = 1'b0;
    x_d2 = '0; x_v2 = 1'b0;
    if (m >= DEPTH) begin
      j = m - DEPTH + 1;
      x_v1 = 1'b1;
      x_d1 = src1(j) + DW'(DEPTH);
      if (j % 2 == 1) begin
        x_v2 = 1'b1;
        x_d2 = DW'((j - 1) / 2) << DEPTH;
      end
    end
  endfunction

  task automatic model_reset();
    e = 0;
    m = 0;
    dep_j = 32'h7fff_ffff;
    dep_val = '0;
    model();
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    if (!stall_at(e)) m++;
    #1;
    model();
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !==
        {x_v1, x_d1, x_v2, x_d2}) begin
      errors++;
      $display("FAIL reset_state got v1=%0b d1=%0h v2=%0b d2=%0h exp all 0",
               out_valid_1, out_data_1, out_valid_2, out_data_2);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_startup();
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !==
          {x_v1, x_d1, x_v2, x_d2}) begin
        errors++;
        $display("FAIL startup e=%0d got %0b/%0h %0b/%0h exp %0b/%0h %0b/%0h",
                 e, out_valid_1, out_data_1, out_valid_2, out_data_2,
                 x_v1, x_d1, x_v2, x_d2);
      end
      if (e <= 3) begin
        checks++;
        if ({out_valid_1, out_valid_2} !== 2'b00) begin
          errors++;
          $display("FAIL early_valid e=%0d got v1=%0b v2=%0b exp 0 0",
                   e, out_valid_1, out_valid_2);
        end
      end
      if (e == 4) begin
        checks++;
        if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !==
            {1'b1, 32'd4, 1'b1, 32'd0}) begin
          errors++;
          $display("FAIL first_out got %0b/%0h %0b/%0h exp 1/4 1/0",
                   out_valid_1, out_data_1, out_valid_2, out_data_2);
        end
      end
      if (e == 5) begin
        checks++;
        if ({out_valid_2, out_data_2} !== {1'b0, 32'd0}) begin
          errors++;
          $display("FAIL bubble e=5 got %0b/%0h exp 0/0",
                   out_valid_2, out_data_2);
        end
      end
      if (e == 6) begin
        checks++;
        if ({out_valid_2, out_data_2} !== {1'b1, 32'd16}) begin
          errors++;
          $display("FAIL p2_second got %0b/%0h exp 1/10",
                   out_valid_2, out_data_2);
        end
      end
`ifdef GLOBAL_STALL_EN
      if (e == 8) begin
        checks++;
        if ({out_valid_1, out_data_1} !== {1'b1, 32'd7}) begin
          errors++;
          $display("FAIL stall_hold e=8 got %0b/%0h exp 1/7",
                   out_valid_1, out_data_1);
        end
      end
      if (e == 9) begin
        checks++;
        if ({out_data_1, out_valid_2, out_data_2} !== {32'd8, 1'b1, 32'd32}) begin
          errors++;
          $display("FAIL after_stall got d1=%0h %0b/%0h exp 8 1/20",
                   out_data_1, out_valid_2, out_data_2);
        end
      end
`endif
    end
  endtask

  task automatic test_stall_period();
    logic [DW-1:0] pd;
    int pm;
    bit held;
    while (e < 256) begin
      pd = out_data_1;
      pm = m;
      tick();
      checks++;
      if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !==
          {x_v1, x_d1, x_v2, x_d2}) begin
        errors++;
        $display("FAIL period e=%0d got %0b/%0h %0b/%0h exp %0b/%0h %0b/%0h",
                 e, out_valid_1, out_data_1, out_valid_2, out_data_2,
                 x_v1, x_d1, x_v2, x_d2);
      end
      if (pm >= DEPTH) begin
        held = (out_data_1 === pd);
        checks++;
        if (held !== stall_at(e)) begin
          errors++;
          $display("FAIL freeze e=%0d got held=%0b exp held=%0b",
                   e, held, stall_at(e));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int pre;
    pre = $urandom_range(12, 30);
    for (int i = 0; i < pre; i++) tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !== '0) begin
      errors++;
      $display("FAIL async_reset got %0b/%0h %0b/%0h exp all 0",
               out_valid_1, out_data_1, out_valid_2, out_data_2);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !==
          {x_v1, x_d1, x_v2, x_d2}) begin
        errors++;
        $display("FAIL post_reset e=%0d got %0b/%0h %0b/%0h exp %0b/%0h %0b/%0h",
                 e, out_valid_1, out_data_1, out_valid_2, out_data_2,
                 x_v1, x_d1, x_v2, x_d2);
      end
    end
  endtask

  task automatic test_wrap();
    int j;
    int skip;
    skip = $urandom_range(0, SP - 1);
    for (int i = 0; i < skip; i++) tick();
    @(negedge clk);
    dut.seq1_q = 32'hFFFF_FFFE;
    dep_val = 32'hFFFF_FFFE;
    dep_j = m + 1;
    for (int i = 0; i < DEPTH + SP + 6; i++) begin
      tick();
      checks++;
      if ({out_valid_1, out_data_1, out_valid_2, out_data_2} !==
          {x_v1, x_d1, x_v2, x_d2}) begin
        errors++;
        $display("FAIL wrap_model e=%0d got %0b/%0h %0b/%0h exp %0b/%0h %0b/%0h",
                 e, out_valid_1, out_data_1, out_valid_2, out_data_2,
                 x_v1, x_d1, x_v2, x_d2);
      end
      j = m - DEPTH + 1;
      if (j == dep_j + 1) begin
        checks++;
        if (out_data_1 !== 32'd3) begin
          errors++;
          $display("FAIL wrap_max got d1=%0h exp 3", out_data_1);
        end
      end
      if (j == dep_j + 2) begin
        checks++;
        if (out_data_1 !== 32'd4) begin
          errors++;
          $display("FAIL wrap_zero got d1=%0h exp 4", out_data_1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall_period();
    test_mid_reset();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_pipeline_top.md
Name: dual_pipeline_top

Overview:
- Self-contained top level holding two independent DEPTH-stage datapath pipelines, each fed by an internal sequence source.
- A single global stall signal freezes both pipelines, both sources and the source toggle flag in the same cycle.
- The global stall comes from an internal periodic generator.
- No data inputs; the block is a demonstrator and stress target for global-stall pipeline control.

Parameters:
- DATA_W, 32, datapath width of both pipelines and of the sequence counters.
- DEPTH, 4, number of register stages per pipeline; legal range 2..8.
- STALL_PERIOD, 8, length of the stall-generator cycle; stall is high for 1 of every STALL_PERIOD cycles; legal range 2..256.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- out_data_1  output  DATA_W  last-stage data of pipeline 1.
- out_data_2  output  DATA_W  last-stage data of pipeline 2.
- out_valid_1  output  1  last-stage valid of pipeline 1.
- out_valid_2  output  1  last-stage valid of pipeline 2.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values (asynchronous, take effect while reset is high, including mid-operation):
  - every stage data and valid = 0, so all outputs = 0;
  - cyc = 0, seq1 = 0, seq2 = 0, tog = 0.
- Stall generator:
  - cyc counts 0..STALL_PERIOD-1 and increments every edge, stalled or not; it wraps to 0.
  - stall = (cyc == STALL_PERIOD-1), combinational.
- Global stall: on an edge with stall=1, every pipeline register, seq1, seq2 and tog hold their values. Outputs hold their data and valid unchanged.
- Source 1, on each non-stall edge:
  - stage 1 loads data = seq1, valid = 1;
  - seq1 increments (wraps mod 2^DATA_W).
- Source 2, on each non-stall edge:
  - if tog=0: stage 1 loads data = seq2, valid = 1, and seq2 increments;
  - if tog=1: stage 1 loads data = 0, valid = 0 (bubble);
  - tog flips on every non-stall edge.
- Stage operations, applied when data moves into stage k from stage k-1 (k = 2..DEPTH), and also to the source value entering stage 1:
  - pipeline 1: data + 1, modulo 2^DATA_W;
  - pipeline 2: data shifted left by 1, zero-filled, bits above DATA_W dropped.
- Invalid slots keep data = 0 through the pipeline.
- End-to-end results:
  - out_data_1 = src + DEPTH (mod 2^DATA_W);
  - out_data_2 = src << DEPTH (truncated);
  - latency = DEPTH non-stall edges from source issue to output.
- Valid moves with its data and is never dropped or duplicated. A stalled slot keeps its valid and is presented again after the stall.
- Outputs come straight from the last-stage registers; there is no combinational path to the outputs.
- No backpressure input; the stall is internal only.

Optional Feature:
- Macro GLOBAL_STALL_EN.
- Defined: the stall generator behaves as described above.
- Undefined: stall is tied to 0 and the generator logic is not built. Pipelines advance on every edge; source 2 still alternates valid and bubble slots.

Test Plan:
- Reset then release, defaults (DEPTH=4, STALL_PERIOD=8):
  - after edges 1-3: out_valid_1 = 0 and out_valid_2 = 0;
  - after edge 4: out_data_1 = 4, out_valid_1 = 1; out_data_2 = 0, out_valid_2 = 1.
- Continue pipeline 1: after edges 5, 6, 7, out_data_1 = 5, 6, 7. Edge 8 is stalled, so out_data_1 stays 7 with valid 1. After edge 9, out_data_1 = 8.
- Pipeline 2 bubbles:
  - after edge 5: valid 0, data 0;
  - after edge 6: valid 1, data 16;
  - after edges 7 and 8 (8 stalled): valid 0;
  - after edge 9: valid 1, data 32.
- Stall periodicity: over 256 edges after reset, outputs freeze exactly on edges 8, 16, 24, ... Every output value appears with no gaps and no repeats apart from those freezes.
- Assert reset for one cycle mid-run (e.g. at edge 20): all outputs = 0 at once, asynchronously. After release, the same sequence as the first scenario repeats.
- Wrap: force seq1 near 2^32-1 (hierarchical deposit). Source value 2^32-1 must produce out_data_1 = 3 and source value 0 must produce out_data_1 = 4. Without GLOBAL_STALL_EN, no output ever holds across an edge.
